// File: rtl/scan_counter_display_if.sv
// scan_counter_display_if: control inputs, counter outputs and display pins of the scan counter.
interface scan_counter_display_if #(
    parameter int DIGITS = 4
);
    logic                  EN;
    logic                  UP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic                  BLANK_LZ;
    logic [4*DIGITS-1:0]   Q;
    logic                  TC;
    logic [0:6]            HEX0;
    logic [7:0]            AN;
    modport master (output EN, UP, LOAD, LOAD_VAL, BLANK_LZ, input Q, TC, HEX0, AN);
    modport slave  (input EN, UP, LOAD, LOAD_VAL, BLANK_LZ, output Q, TC, HEX0, AN);
endinterface

// File: rtl/scan_counter_display.sv
// scan_counter_display: N-digit hex/BCD up/down counter driving a multiplexed 7-segment display.
module scan_counter_display #(
    parameter int DIGITS    = 4,
    parameter int COUNT_DIV = 10000,
    parameter int SCAN_DIV  = 50000,
    parameter int MODE_BCD  = 0
) (
    input logic                   CLK100MHZ,
    input logic                   CPU_RESETN,
    scan_counter_display_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DMAX = MODE_BCD != 0 ? 4'd9 : 4'd15;
    localparam logic [0:6] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [CW-1:0] cdiv_q, cdiv_d;
    logic [SW-1:0] sdiv_q, sdiv_d;
    logic [2:0]    idx_q, idx_d;
    logic [W-1:0]  q_q, q_d, inc, dec;
    logic          tc_q, tc_d;
    logic [7:0]    an_q, an_d;
    logic [0:6]    hex_q, hex_d;
    logic          count_tick, scan_tick, go, carry, borrow, nz, blank;
    logic [3:0]    dig;
    always_comb begin
        count_tick = cdiv_q == CW'(COUNT_DIV - 1);
        scan_tick  = sdiv_q == SW'(SCAN_DIV - 1);
        cdiv_d     = count_tick ? '0 : cdiv_q + 1'b1;
        sdiv_d     = scan_tick ? '0 : sdiv_q + 1'b1;
        carry      = 1'b1;
        borrow     = 1'b1;
        inc        = q_q;
        dec        = q_q;
        // digits at/above DMAX roll to 0 on carry, so out-of-range BCD loads behave like 9
        for (int i = 0; i < DIGITS; i++) begin
            inc[4*i +: 4] = (carry && q_q[4*i +: 4] >= DMAX) ? 4'd0 : q_q[4*i +: 4] + {3'd0, carry};
            dec[4*i +: 4] = (borrow && q_q[4*i +: 4] == 4'd0) ? DMAX : q_q[4*i +: 4] - {3'd0, borrow};
            carry  = carry && q_q[4*i +: 4] >= DMAX;
            borrow = borrow && q_q[4*i +: 4] == 4'd0;
        end
        go    = count_tick && bus.EN && !bus.LOAD;
        q_d   = bus.LOAD ? bus.LOAD_VAL : go ? (bus.UP ? inc : dec) : q_q;
        tc_d  = go && (bus.UP ? carry : borrow);
        idx_d = scan_tick ? (idx_q == 3'(DIGITS - 1) ? 3'd0 : idx_q + 3'd1) : idx_q;
        dig   = 4'(q_q >> {idx_d, 2'b00});
        nz    = |(q_q >> {idx_d, 2'b00});
        blank = bus.BLANK_LZ && idx_d != 3'd0 && !nz;
        an_d  = scan_tick ? ~(8'd1 << idx_d) : an_q;
        hex_d = scan_tick ? (blank ? 7'b1111111 : SEG[dig]) : hex_q;
    end
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cdiv_q <= '0;
            sdiv_q <= '0;
            idx_q  <= '0;
            q_q    <= '0;
            tc_q   <= 1'b0;
            an_q   <= 8'hFF;
            hex_q  <= 7'b1111111;
        end else begin
            cdiv_q <= cdiv_d;
            sdiv_q <= sdiv_d;
            idx_q  <= idx_d;
            q_q    <= q_d;
            tc_q   <= tc_d;
            an_q   <= an_d;
            hex_q  <= hex_d;
        end
    end
    assign bus.Q    = q_q;
    assign bus.TC   = tc_q;
    assign bus.HEX0 = hex_q;
    assign bus.AN   = an_q;
endmodule

// File: tb/tb_scan_counter_display.sv
// tb_scan_counter_display: random stimulus on three configurations, scoreboarded against a value-level model.
module tb_scan_counter_display;
    localparam int NU = 3;
    localparam int DG [NU] = '{4, 3, 8};
    localparam int CD [NU] = '{4, 2, 1};
    localparam int SD [NU] = '{3, 1, 1};
    localparam int BC [NU] = '{0, 1, 0};
    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct { int e; logic [31:0] q; logic tc; } cexp_t;
    typedef struct { int e; logic [7:0] an; logic [6:0] hex; } dexp_t;

    cexp_t cq [NU][$];
    dexp_t dq [NU][$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en, up, load, blz;
    logic [31:0] lv [NU];
    logic [31:0] oq [NU];
    logic        otc [NU];
    logic [7:0]  oan [NU];
    logic [6:0]  ohex [NU];
    int checks = 0, errors = 0, edges = 0, me = 0;
    bit run = 1'b0;
    logic [31:0] mq [NU];
    int mcp [NU], msp [NU], midx [NU];
    logic [7:0] an_prev [NU];

    scan_counter_display_if #(.DIGITS(4)) b0();
    scan_counter_display_if #(.DIGITS(3)) b1();
    scan_counter_display_if #(.DIGITS(8)) b2();

    assign b0.EN = en;  assign b0.UP = up;  assign b0.LOAD = load;  assign b0.BLANK_LZ = blz;
    assign b1.EN = en;  assign b1.UP = up;  assign b1.LOAD = load;  assign b1.BLANK_LZ = blz;
    assign b2.EN = en;  assign b2.UP = up;  assign b2.LOAD = load;  assign b2.BLANK_LZ = blz;
    assign b0.LOAD_VAL = lv[0][15:0];
    assign b1.LOAD_VAL = lv[1][11:0];
    assign b2.LOAD_VAL = lv[2];

    assign oq[0] = 32'(b0.Q);  assign otc[0] = b0.TC;  assign oan[0] = b0.AN;  assign ohex[0] = b0.HEX0;
    assign oq[1] = 32'(b1.Q);  assign otc[1] = b1.TC;  assign oan[1] = b1.AN;  assign ohex[1] = b1.HEX0;
    assign oq[2] = b2.Q;       assign otc[2] = b2.TC;  assign oan[2] = b2.AN;  assign ohex[2] = b2.HEX0;

    scan_counter_display #(.DIGITS(4), .COUNT_DIV(4), .SCAN_DIV(3), .MODE_BCD(0)) u_hex4 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .bus(b0.slave));
    scan_counter_display #(.DIGITS(3), .COUNT_DIV(2), .SCAN_DIV(1), .MODE_BCD(1)) u_bcd3 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .bus(b1.slave));
    scan_counter_display #(.DIGITS(8), .COUNT_DIV(1), .SCAN_DIV(1), .MODE_BCD(0)) u_hex8 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .bus(b2.slave));

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;

    task automatic chk(string n, int u, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s unit%0d edge %0d got %h want %h", n, u, edges, a, x);
        end
    endtask

    function automatic logic [31:0] rand_val(int u);
        logic [31:0] v;
        int r;
        v = '0;
        r = $urandom_range(0, 3);
        for (int i = 0; i < DG[u]; i++)
            v[4*i +: 4] = r == 0 ? 4'd0 : r == 1 ? (BC[u] != 0 ? 4'd9 : 4'd15) :
                          (BC[u] != 0 && r == 2) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Advance the reference by one clock edge and queue what the DUT must show after it.
    task automatic model_step(int u);
        logic [31:0] q;
        logic        tc;
        bit          ct, c;
        int          k, d;
        longint      m, v;
        q  = mq[u];
        tc = 1'b0;
        if (msp[u] == SD[u] - 1) begin
            msp[u]  = 0;
            midx[u] = (midx[u] + 1) % DG[u];
            k       = midx[u];
            dq[u].push_back(dexp_t'{me, ~(8'd1 << k),
                (blz && k > 0 && (q >> (4*k)) == 0) ? 7'h7F : SEG[4'(q >> (4*k))]});
        end else msp[u]++;
        ct     = mcp[u] == CD[u] - 1;
        mcp[u] = ct ? 0 : mcp[u] + 1;
        if (load) q = lv[u];
        else if (ct && en) begin
            if (BC[u] == 0) begin
                m  = longint'(1) << (4 * DG[u]);
                v  = longint'(q);
                tc = up ? v == m - 1 : v == 0;
                v  = up ? (v + 1) % m : (v + m - 1) % m;
                q  = 32'(v);
            end else begin
                c = 1'b1;
                for (int i = 0; i < DG[u] && c; i++) begin
                    d = int'(q[4*i +: 4]);
                    if (up) begin
                        c = d >= 9;
                        q[4*i +: 4] = c ? 4'd0 : 4'(d + 1);
                    end else begin
                        c = d == 0;
                        q[4*i +: 4] = c ? 4'd9 : 4'(d - 1);
                    end
                end
                tc = c;
            end
        end
        mq[u] = q;
        cq[u].push_back(cexp_t'{me, q, tc});
    endtask

    task automatic mon(int u);
        cexp_t c;
        dexp_t d;
        if (run && cq[u].size() > 0 && cq[u][0].e == edges) begin
            c = cq[u].pop_front();
            chk("q", u, oq[u], c.q);
            chk("tc", u, 32'(otc[u]), 32'(c.tc));
        end
        if (run && oan[u] != an_prev[u]) begin
            if (dq[u].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scan_unexpected unit%0d edge %0d got an %h want no change", u, edges, oan[u]);
            end else begin
                d = dq[u].pop_front();
                chk("scan_edge", u, edges, d.e);
                chk("an", u, 32'(oan[u]), 32'(d.an));
                chk("hex0", u, 32'(ohex[u]), 32'(d.hex));
            end
        end
        an_prev[u] = oan[u];
    endtask

    always @(negedge clk)
        for (int u = 0; u < NU; u++) mon(u);

    task automatic reset_model();
        for (int u = 0; u < NU; u++) begin
            cq[u].delete();
            dq[u].delete();
            mq[u]   = '0;
            mcp[u]  = 0;
            msp[u]  = 0;
            midx[u] = 0;
        end
        me = 0;
    endtask

    task automatic reset_checks();
        for (int u = 0; u < NU; u++) begin
            chk("rst_q", u, oq[u], 32'd0);
            chk("rst_tc", u, 32'(otc[u]), 32'd0);
            chk("rst_an", u, 32'(oan[u]), 32'hFF);
            chk("rst_hex0", u, 32'(ohex[u]), 32'h7F);
        end
    endtask

    initial begin
        en = 1'b1; up = 1'b1; load = 1'b0; blz = 1'b1;
        for (int u = 0; u < NU; u++) begin
            lv[u] = '0;
            an_prev[u] = 8'hFF;
        end
        reset_model();
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        run   = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) begin
                load = 1'b1;
                for (int u = 0; u < NU; u++) lv[u] = 32'h42;
                me++;
                for (int u = 0; u < NU; u++) model_step(u);
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                run   = 1'b0;
                #1;
                reset_checks();
                reset_model();
                load = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                run   = 1'b1;
            end
            en   = $urandom_range(0, 9) != 0;
            load = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 49) == 0) up = ~up;
            if ($urandom_range(0, 99) == 0) blz = ~blz;
            for (int u = 0; u < NU; u++) lv[u] = rand_val(u);
            me++;
            for (int u = 0; u < NU; u++) model_step(u);
            @(negedge clk);
        end
        #1;
        run = 1'b0;
        for (int u = 0; u < NU; u++) begin
            chk("count_drain", u, cq[u].size(), 0);
            chk("scan_drain", u, dq[u].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_counter_display.md
Name: scan_counter_display

Overview:
- Parametrised N-digit up/down counter with an integrated multiplexed 7-segment scan driver for the board's 8-digit display.
- Hex or BCD counting; synchronous load; terminal-count pulse; optional leading-zero blanking.
- All timing comes from clock-enable ticks generated inside the block on the single CLK100MHZ domain; no derived clocks.
- Sits between top-level control inputs and the HEX0/AN display pins.

Parameters:
- DIGITS, 4, number of counter digits/display positions, legal 1..8.
- COUNT_DIV, 10000, CLK100MHZ cycles per count tick, legal >=1; 1 means a tick every cycle.
- SCAN_DIV, 50000, CLK100MHZ cycles per scan step (one digit position), legal >=1.
- MODE_BCD, 0, 0 = hex digits (modulus 16^DIGITS), 1 = decimal digits (modulus 10^DIGITS).

Ports:
- CLK100MHZ  in  1  system clock; all state updates on its rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- EN  in  1  count enable, sampled on count ticks.
- UP  in  1  1 = increment, 0 = decrement.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  4*DIGITS  value loaded into Q.
- BLANK_LZ  in  1  1 = blank leading zero digits.
- Q  out  4*DIGITS  counter value; digit i = Q[4i+3:4i], digit 0 least significant.
- TC  out  1  one-cycle terminal-count pulse.
- HEX0  out  [0:6]  segments a..g, active-low; HEX0[0] = a.
- AN  out  8  digit anodes, active-low; AN[i] drives digit i.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous, effective immediately, including mid-count or mid-scan):
  - Q=0, TC=0, HEX0=7'b1111111, AN=8'hFF.
  - Both prescalers = 0; scan index = 0.
- Count prescaler:
  - Runs 0..COUNT_DIV-1 continuously, independent of EN and LOAD.
  - count_tick is asserted in the cycle the prescaler equals COUNT_DIV-1; the prescaler then wraps to 0.
- Counter update, registered, priority order:
  - LOAD=1: Q <= LOAD_VAL on the next edge. Any coincident tick is discarded; TC=0.
  - Else count_tick & EN & UP: Q <= Q+1 with per-digit carry.
    - Hex: a digit at F becomes 0 and carries.
    - BCD: a digit >=9 becomes 0 and carries.
  - Else count_tick & EN & ~UP: Q <= Q-1 with per-digit borrow.
    - A digit at 0 becomes F (hex) or 9 (BCD) and borrows.
  - Otherwise Q holds.
- Wrap-around:
  - Up from MAX goes to 0; down from 0 goes to MAX.
  - MAX = all digits F (hex) or all digits 9 (BCD).
  - TC=1 for exactly the cycle after the edge on which the wrap occurs (registered with Q); TC=0 otherwise.
- BCD LOAD_VAL digits >9 are loaded unchanged. The next increment treats them as 9 (becomes 0 with carry). The next decrement subtracts 1 normally.
- Scan prescaler:
  - Runs 0..SCAN_DIV-1; scan_tick is asserted at SCAN_DIV-1.
  - On scan_tick the index advances 0,1,..,DIGITS-1,0 (wraps after DIGITS-1).
- Display outputs, registered and updated only on scan_tick, from the new index k and the current Q:
  - AN: bit k = 0, all other bits = 1. Bits >= DIGITS are always 1.
  - HEX0 = decode(digit k).
  - Blanking: if BLANK_LZ=1, k>0 and digits k..DIGITS-1 are all 0, then HEX0=7'b1111111 while AN[k] stays 0. Digit 0 is never blanked.
  - Latency: a Q change is visible on the display no later than DIGITS scan steps afterwards.
- Segment decode (HEX0[0:6]), same table in both modes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- With DIGITS=1, AN toggles only bit 0 (held 0 after the first scan_tick).

Test Plan:
- DIGITS=4, COUNT_DIV=4, hex, EN=1, UP=1, LOAD_VAL=16'hFFFE pulsed.
  - Q goes FFFF after 4 cycles.
  - Q goes 0000 after 8 cycles, with TC high for exactly 1 cycle.
  - No other TC pulses.
- MODE_BCD=1, load 16'h0999, UP=1: next tick Q=16'h1000. Then UP=0, load 16'h0000: next tick Q=16'h9999, TC=1 for 1 cycle.
- LOAD asserted in the same cycle as count_tick with LOAD_VAL=16'h1234, Q=16'h00FF, UP=1: Q=16'h1234 (not 0100), TC=0. EN=0: Q holds across 10 ticks.
- SCAN_DIV=3, Q=16'h00A5, BLANK_LZ=1, checked on successive scan_ticks:
  - AN cycles FE (HEX0 0100100), FD (HEX0 0001000), FB (HEX0 1111111), F7 (HEX0 1111111).
  - With BLANK_LZ=0, AN=FB and AN=F7 show 0000001.
- Pull CPU_RESETN low asynchronously mid-count (Q=16'h0042) between clock edges: Q=0, TC=0, AN=FF, HEX0=7F immediately, without waiting for a clock edge. After release, the first count tick arrives COUNT_DIV cycles later.
- DIGITS=8, SCAN_DIV=1: AN walks FE,FD,...,7F,FE on consecutive cycles; DIGITS=3: AN[7:3] are always 1.
